// File: rtl/nocif_dram_write_eg_rsp_if.sv
// ---------------------------------------------------------------------------
// nocif_dram_write_eg_rsp_if
//
// Purpose:
//   Bundles the signals of the DRAM write-response egress stage.
//   These are the NoC B channel, the per-thread context-queue read port,
//   the burst-retire return path to ingress, the per-client write-complete
//   pulses and the error status.
//
// Modports:
//   slave  - the egress stage itself. It receives B responses and cq entries,
//            and drives bready, cq pops, eg2ig, completes and error status.
//   master - the surrounding environment (NoC / context queue / clients).
//
// Signals:
//   noc2mcif_axi_b_bvalid/bready/bid/bresp  AXI B channel (bid[3:0] = thread)
//   cq_rd_pvld/prdy/pd                      per-thread context queue, 3 bits
//                                           per thread {require_ack, len[1:0]}
//   eg2ig_axi_vld/len                       burst-retired pulse and its len
//   mcif2client_wr_rsp_complete             per-client write-ack pulse
//   eg_err_sticky / eg_err_cnt              error flag and saturating count
// ---------------------------------------------------------------------------
interface nocif_dram_write_eg_rsp_if #(
  parameter int NUM_CLIENTS = 5
);
  logic                       noc2mcif_axi_b_bvalid;
  logic                       noc2mcif_axi_b_bready;
  logic [7:0]                 noc2mcif_axi_b_bid;
  logic [1:0]                 noc2mcif_axi_b_bresp;
  logic [NUM_CLIENTS-1:0]     cq_rd_pvld;
  logic [NUM_CLIENTS-1:0]     cq_rd_prdy;
  logic [3*NUM_CLIENTS-1:0]   cq_rd_pd;
  logic                       eg2ig_axi_vld;
  logic [1:0]                 eg2ig_axi_len;
  logic [NUM_CLIENTS-1:0]     mcif2client_wr_rsp_complete;
  logic                       eg_err_sticky;
  logic [7:0]                 eg_err_cnt;

  modport slave (
    input  noc2mcif_axi_b_bvalid,
    input  noc2mcif_axi_b_bid,
    input  noc2mcif_axi_b_bresp,
    input  cq_rd_pvld,
    input  cq_rd_pd,
    output noc2mcif_axi_b_bready,
    output cq_rd_prdy,
    output eg2ig_axi_vld,
    output eg2ig_axi_len,
    output mcif2client_wr_rsp_complete,
    output eg_err_sticky,
    output eg_err_cnt
  );

  modport master (
    output noc2mcif_axi_b_bvalid,
    output noc2mcif_axi_b_bid,
    output noc2mcif_axi_b_bresp,
    output cq_rd_pvld,
    output cq_rd_pd,
    input  noc2mcif_axi_b_bready,
    input  cq_rd_prdy,
    input  eg2ig_axi_vld,
    input  eg2ig_axi_len,
    input  mcif2client_wr_rsp_complete,
    input  eg_err_sticky,
    input  eg_err_cnt
  );
endinterface

// File: rtl/nocif_dram_write_eg_rsp.sv
// ---------------------------------------------------------------------------
// nocif_dram_write_eg_rsp
//
// Purpose:
//   Write-response egress stage. Each AXI B response is held in a single
//   stage (S0) until the context-queue entry of its thread is available. The
//   entry is then popped, the burst length is returned to ingress, and a
//   write-complete pulse is raised to the client if the request asked for an
//   ack. Responses retire strictly in arrival order. A response for a
//   non-existent thread is dropped. It raises no pop and no pulse, and it is
//   counted as an error, as is any non-OKAY bresp.
//
// Ports:
//   nvdla_core_clk  - core clock
//   nvdla_core_rst  - asynchronous active-high reset
//   bus             - nocif_dram_write_eg_rsp_if.slave (B channel, cq read
//                     port, eg2ig return, client completes, error status)
//
// Timing: B handshake at N -> S0 valid at N+1 -> pop at N+1 if the cq entry
// is present -> eg2ig / complete pulses at N+2.
// ---------------------------------------------------------------------------
module nocif_dram_write_eg_rsp #(
  parameter int NUM_CLIENTS = 5
) (
  input  logic                              nvdla_core_clk,
  input  logic                              nvdla_core_rst,
  nocif_dram_write_eg_rsp_if.slave          bus
);

  // S0: the one outstanding B response
  logic                   s0_vld_q,   s0_vld_d;
  logic [3:0]             s0_tid_q,   s0_tid_d;
  logic [1:0]             s0_bresp_q, s0_bresp_d;

  // registered outputs
  logic                   eg_vld_q,   eg_vld_d;
  logic [1:0]             eg_len_q,   eg_len_d;
  logic [NUM_CLIENTS-1:0] cmp_q,      cmp_d;
  logic                   err_sticky_q, err_sticky_d;
  logic [7:0]             err_cnt_q,  err_cnt_d;

  // combinational control
  logic [NUM_CLIENTS-1:0] pop_hit;
  logic [2:0]             pop_pd;
  logic                   pop_any;
  logic                   tid_ok;
  logic                   s0_retire;
  logic                   b_ready;
  logic                   b_hs;
  logic                   err_evt;

  // Only thread ids below NUM_CLIENTS own a context queue. The compare is
  // done one bit wider so that NUM_CLIENTS=16 still works.
  assign tid_ok = ({1'b0, s0_tid_q} < 5'(NUM_CLIENTS));

  // One-hot pop: at most one thread matches s0_tid, and only while that
  // thread presents a valid entry.
  generate
    for (genvar gi = 0; gi < NUM_CLIENTS; gi++) begin : g_pop
      assign pop_hit[gi] = s0_vld_q & (s0_tid_q == 4'(gi)) & bus.cq_rd_pvld[gi];
    end
  endgenerate

  assign pop_any = |pop_hit;

  // An AND-OR select keeps cq_rd_pd out of the datapath except on the cycle
  // of a pop, so an undefined entry on an idle thread never leaks through.
  always_comb begin
    pop_pd = 3'd0;
    for (int t = 0; t < NUM_CLIENTS; t++) begin
      pop_pd = pop_pd | ({3{pop_hit[t]}} & bus.cq_rd_pd[3*t +: 3]);
    end
  end

  // Retire when the thread's entry is popped, or immediately for a bogus
  // thread id. Ready is open whenever S0 is empty or leaves this cycle. This
  // gives back-to-back throughput with no bubble.
  assign s0_retire = s0_vld_q & (~tid_ok | pop_any);
  assign b_ready   = ~s0_vld_q | s0_retire;
  assign b_hs      = bus.noc2mcif_axi_b_bvalid & b_ready;
  assign err_evt   = s0_retire & (~tid_ok | (s0_bresp_q != 2'b00));

  always_comb begin
    s0_vld_d   = s0_vld_q;
    s0_tid_d   = s0_tid_q;
    s0_bresp_d = s0_bresp_q;
    if (b_hs) begin
      s0_vld_d   = 1'b1;
      s0_tid_d   = bus.noc2mcif_axi_b_bid[3:0];
      s0_bresp_d = bus.noc2mcif_axi_b_bresp;
    end else if (s0_retire) begin
      s0_vld_d   = 1'b0;
    end
  end

  always_comb begin
    eg_vld_d = pop_any;
    eg_len_d = pop_any ? pop_pd[1:0] : eg_len_q;   // len holds between pulses
    cmp_d    = pop_hit & {NUM_CLIENTS{pop_pd[2]}};
  end

  always_comb begin
    err_sticky_d = err_sticky_q | err_evt;
    err_cnt_d    = err_cnt_q;
    if (err_evt && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      s0_vld_q     <= 1'b0;
      s0_tid_q     <= 4'd0;
      s0_bresp_q   <= 2'd0;
      eg_vld_q     <= 1'b0;
      eg_len_q     <= 2'd0;
      cmp_q        <= '0;
      err_sticky_q <= 1'b0;
      err_cnt_q    <= 8'd0;
    end else begin
      s0_vld_q     <= s0_vld_d;
      s0_tid_q     <= s0_tid_d;
      s0_bresp_q   <= s0_bresp_d;
      eg_vld_q     <= eg_vld_d;
      eg_len_q     <= eg_len_d;
      cmp_q        <= cmp_d;
      err_sticky_q <= err_sticky_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign bus.noc2mcif_axi_b_bready       = b_ready;
  assign bus.cq_rd_prdy                  = pop_hit;
  assign bus.eg2ig_axi_vld               = eg_vld_q;
  assign bus.eg2ig_axi_len               = eg_len_q;
  assign bus.mcif2client_wr_rsp_complete = cmp_q;
  assign bus.eg_err_sticky               = err_sticky_q;
  assign bus.eg_err_cnt                  = err_cnt_q;

endmodule
